pipe_hazard_ctrl: RTL and testbench

- Central interlock and sequencing controller for the in-order RV32 pipeline.
- Holds a per-register scoreboard of in-flight writers, updated from decode issue and writeback retire.
- Generates the decode/fetch stall when a source register has an unretired writer, and generates the pipeline flush window after an EX-stage redirect (taken branch, JAL, JALR).
- Sits beside the decode stage: its stall/flush outputs drive the decode stage's stall and flush inputs and the fetch PC hold.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/hz_scoreboard.sv | 77 +++++++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RV32 pipeline hazard controller.
//   hz_state_e  : sequencing state (normal run / flush window)
//   REG_IDX_W   : architectural register index width
//   issue_req_t : bundle of the decode-stage issue fields
package riscv_pkg;

   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [0:0] {
      HZ_RUN,
      HZ_FLUSH
   } hz_state_e;

   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rs1_idx;
      logic [REG_IDX_W-1:0] rs2_idx;
      logic                 rs1_used;
      logic                 rs2_used;
      logic [REG_IDX_W-1:0] rd_addr;
      logic                 rd_wrt_ena;
   } issue_req_t;

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register scoreboard of in-flight writers.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   inc_i, inc_addr_i     : one more writer issued to inc_addr_i (caller excludes x0)
//   dec_i, dec_addr_i     : one writer retired from dec_addr_i (caller excludes x0)
//   rs1_idx_i, rs2_idx_i  : source lookups
//   rd_idx_i              : destination lookup
//   rs1_busy_o, rs2_busy_o: source still has an unretired writer after same-cycle WB
//   rd_full_o             : destination already has MAX_INFLIGHT writers and none retire now
module hz_scoreboard
   import riscv_pkg::*;
#(
   parameter int unsigned NREG         = 32,
   parameter int unsigned MAX_INFLIGHT = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inc_i,
   input  logic [REG_IDX_W-1:0] inc_addr_i,
   input  logic                 dec_i,
   input  logic [REG_IDX_W-1:0] dec_addr_i,
   input  logic [REG_IDX_W-1:0] rs1_idx_i,
   input  logic [REG_IDX_W-1:0] rs2_idx_i,
   input  logic [REG_IDX_W-1:0] rd_idx_i,
   output logic                 rs1_busy_o,
   output logic                 rs2_busy_o,
   output logic                 rd_full_o
);

   localparam int unsigned PW = $clog2(MAX_INFLIGHT + 1);

   logic [PW-1:0]   r_pend [NREG];
   logic [NREG-1:0] w_inc_vec;
   logic [NREG-1:0] w_dec_vec;
   logic            w_dec_rs1;
   logic            w_dec_rs2;
   logic            w_dec_rd;

   always_comb begin
      w_inc_vec = '0;
      w_dec_vec = '0;
      for (int r = 1; r < NREG; r++) begin
         w_inc_vec[r] = inc_i && (inc_addr_i == REG_IDX_W'(r));
         w_dec_vec[r] = dec_i && (dec_addr_i == REG_IDX_W'(r));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pend <= '{default: '0};
      end else begin
         for (int r = 1; r < NREG; r++) begin
            // Simultaneous issue and retire on one register cancel out.
            if (w_inc_vec[r] && !w_dec_vec[r]) begin
               if (r_pend[r] != PW'(MAX_INFLIGHT)) r_pend[r] <= r_pend[r] + PW'(1);
            end else if (w_dec_vec[r] && !w_inc_vec[r]) begin
               if (r_pend[r] != '0) r_pend[r] <= r_pend[r] - PW'(1);
            end
         end
      end
   end

   assign w_dec_rs1 = dec_i && (dec_addr_i == rs1_idx_i);
   assign w_dec_rs2 = dec_i && (dec_addr_i == rs2_idx_i);
   assign w_dec_rd  = dec_i && (dec_addr_i == rd_idx_i);

   // The register file writes on negedge, so a same-cycle retire already satisfies the
   // reader; "pend > dec" is pend - dec != 0 without underflowing on a stray retire.
   assign rs1_busy_o = r_pend[rs1_idx_i] > PW'(w_dec_rs1);
   assign rs2_busy_o = r_pend[rs2_idx_i] > PW'(w_dec_rs2);
   assign rd_full_o  = (r_pend[rd_idx_i] == PW'(MAX_INFLIGHT)) && !w_dec_rd;

   // Retiring a register with no recorded writer means the pipeline lost track of it.
   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(dec_i && (r_pend[dec_addr_i] == '0)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Interlock and sequencing controller for the in-order RV32 pipeline.
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   issue_*_i              : instruction currently held in decode
//   redirect_i             : EX resolved a taken control transfer this cycle
//   wb_valid_i, wb_addr_i  : writeback commit
//   stallD_o               : hold fetch PC / decode input, inject NOP downstream
//   flush_o                : squash fetch/decode contents
//   issue_accept_o         : decode instruction advances this cycle
//   stall_cnt_o            : count of stalled cycles (registered)
//   flush_cnt_o            : count of redirects (registered)
module pipe_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned NREG         = 32,
   parameter int unsigned MAX_INFLIGHT = 3,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 issue_valid_i,
   input  logic [REG_IDX_W-1:0] issue_rs1_idx_i,
   input  logic [REG_IDX_W-1:0] issue_rs2_idx_i,
   input  logic                 issue_rs1_used_i,
   input  logic                 issue_rs2_used_i,
   input  logic [REG_IDX_W-1:0] issue_rd_addr_i,
   input  logic                 issue_rd_wrt_ena_i,
   input  logic                 redirect_i,
   input  logic                 wb_valid_i,
   input  logic [REG_IDX_W-1:0] wb_addr_i,
   output logic                 stallD_o,
   output logic                 flush_o,
   output logic                 issue_accept_o,
   output logic [CNT_W-1:0]     stall_cnt_o,
   output logic [CNT_W-1:0]     flush_cnt_o
);

   // Countdown holds the flush cycles still owed after the current one.
   localparam logic [3:0] CD_LOAD = 4'(FLUSH_CYCLES - 1);

   issue_req_t  w_issue;
   hz_state_e   r_state;
   logic [3:0]  r_cd;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic w_rs1_busy;
   logic w_rs2_busy;
   logic w_rd_full;
   logic w_raw;
   logic w_full;
   logic w_flush;
   logic w_stall;
   logic w_accept;
   logic w_inc;
   logic w_dec;

   assign w_issue = '{
      valid:      issue_valid_i,
      rs1_idx:    issue_rs1_idx_i,
      rs2_idx:    issue_rs2_idx_i,
      rs1_used:   issue_rs1_used_i,
      rs2_used:   issue_rs2_used_i,
      rd_addr:    issue_rd_addr_i,
      rd_wrt_ena: issue_rd_wrt_ena_i
   };

   assign w_inc = w_accept && w_issue.rd_wrt_ena && (w_issue.rd_addr != '0);
   assign w_dec = wb_valid_i && (wb_addr_i != '0);

   hz_scoreboard #(
      .NREG         (NREG),
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (w_inc),
      .inc_addr_i (w_issue.rd_addr),
      .dec_i      (w_dec),
      .dec_addr_i (wb_addr_i),
      .rs1_idx_i  (w_issue.rs1_idx),
      .rs2_idx_i  (w_issue.rs2_idx),
      .rd_idx_i   (w_issue.rd_addr),
      .rs1_busy_o (w_rs1_busy),
      .rs2_busy_o (w_rs2_busy),
      .rd_full_o  (w_rd_full)
   );

   assign w_raw = (w_issue.rs1_used && (w_issue.rs1_idx != '0) && w_rs1_busy) ||
                  (w_issue.rs2_used && (w_issue.rs2_idx != '0) && w_rs2_busy);
   assign w_full = w_issue.rd_wrt_ena && (w_issue.rd_addr != '0) && w_rd_full;

   // Flush wins over stall: anything in decode is younger than the redirect.
   assign w_flush  = !rst_i && (redirect_i || (r_state == HZ_FLUSH));
   assign w_stall  = !rst_i && w_issue.valid && (w_raw || w_full) && !w_flush;
   assign w_accept = !rst_i && w_issue.valid && !w_stall && !w_flush;

   assign flush_o        = w_flush;
   assign stallD_o       = w_stall;
   assign issue_accept_o = w_accept;
   assign stall_cnt_o    = r_stall_cnt;
   assign flush_cnt_o    = r_flush_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= HZ_RUN;
         r_cd        <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall)    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (redirect_i) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         case (r_state)
            HZ_RUN: begin
               if (redirect_i && (FLUSH_CYCLES > 1)) begin
                  r_state <= HZ_FLUSH;
                  r_cd    <= CD_LOAD;
               end
            end
            HZ_FLUSH: begin
               if (redirect_i) begin
                  r_cd <= CD_LOAD;
               end else if (r_cd <= 4'd1) begin
                  r_state <= HZ_RUN;
                  r_cd    <= '0;
               end else begin
                  r_cd <= r_cd - 4'd1;
               end
            end
            default: r_state <= HZ_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a register-count model of the interlock rules.
module tb_pipe_hazard_ctrl;

   localparam int FC  = 2;
   localparam int MAX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [4:0]  rs1, rs2, rd;
   logic        u1, u2, wr;
   logic        redirect;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic        stallD, flush, accept;
   logic [31:0] stall_cnt, flush_cnt;

   int          n_cmp = 0;
   int          n_err = 0;

   // Reference model state
   int          pend_m [32];
   int          flush_left;
   logic [31:0] stall_m, flush_m;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .NREG         (32),
      .MAX_INFLIGHT (MAX),
      .FLUSH_CYCLES (FC),
      .CNT_W        (32)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .issue_valid_i      (issue_valid),
      .issue_rs1_idx_i    (rs1),
      .issue_rs2_idx_i    (rs2),
      .issue_rs1_used_i   (u1),
      .issue_rs2_used_i   (u2),
      .issue_rd_addr_i    (rd),
      .issue_rd_wrt_ena_i (wr),
      .redirect_i         (redirect),
      .wb_valid_i         (wb_valid),
      .wb_addr_i          (wb_addr),
      .stallD_o           (stallD),
      .flush_o            (flush),
      .issue_accept_o     (accept),
      .stall_cnt_o        (stall_cnt),
      .flush_cnt_o        (flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int eff(input int r);
      return pend_m[r] - ((wb_valid && int'(wb_addr) == r) ? 1 : 0);
   endfunction

   task automatic iss(input bit v, input int a1, input bit b1, input int a2, input bit b2,
                      input int d, input bit w);
      issue_valid = v;
      rs1 = 5'(a1); u1 = b1;
      rs2 = 5'(a2); u2 = b2;
      rd  = 5'(d);  wr = w;
   endtask

   task automatic idle();
      iss(0, 0, 0, 0, 0, 0, 0);
      redirect = 0;
      wb_valid = 0;
      wb_addr  = 0;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   // Optional xs/xf/xa give explicit expected stall/flush/accept for directed steps.
   task automatic step(input int xs = -1, input int xf = -1, input int xa = -1);
      bit raw, full, e_fl, e_st, e_ac;
      @(negedge clk);
      raw  = (u1 && rs1 != 0 && eff(int'(rs1)) != 0) || (u2 && rs2 != 0 && eff(int'(rs2)) != 0);
      full = wr && rd != 0 && pend_m[rd] == MAX && !(wb_valid && wb_addr == rd);
      e_fl = !rst && (redirect || flush_left > 0);
      e_st = !rst && issue_valid && (raw || full) && !e_fl;
      e_ac = !rst && issue_valid && !e_st && !e_fl;
      chk("stallD", 32'(stallD), 32'(e_st));
      chk("flush", 32'(flush), 32'(e_fl));
      chk("accept", 32'(accept), 32'(e_ac));
      chk("stall_cnt", stall_cnt, stall_m);
      chk("flush_cnt", flush_cnt, flush_m);
      if (xs >= 0) chk("dir_stall", 32'(stallD), 32'(xs));
      if (xf >= 0) chk("dir_flush", 32'(flush), 32'(xf));
      if (xa >= 0) chk("dir_accept", 32'(accept), 32'(xa));
      @(posedge clk);
      if (rst) begin
         foreach (pend_m[i]) pend_m[i] = 0;
         flush_left = 0;
         stall_m    = 0;
         flush_m    = 0;
      end else begin
         if (e_ac && wr && rd != 0) pend_m[rd]++;
         if (wb_valid && wb_addr != 0 && pend_m[wb_addr] > 0) pend_m[wb_addr]--;
         if (e_st) stall_m++;
         if (redirect) flush_m++;
         if (redirect) flush_left = FC - 1;
         else if (flush_left > 0) flush_left--;
      end
      #1;
   endtask

   initial begin
      int cand [$];
      foreach (pend_m[i]) pend_m[i] = 0;
      flush_left = 0;
      stall_m    = 0;
      flush_m    = 0;
      idle();
      rst = 1;
      step(0, 0, 0);
      step(0, 0, 0);
      rst = 0;

      // Back-to-back RAW, released by same-cycle writeback
      iss(1, 0, 0, 0, 0, 5, 1); step(0, 0, 1);
      iss(1, 5, 1, 0, 0, 0, 0); step(1, 0, 0); step(1, 0, 0);
      wb_valid = 1; wb_addr = 5; step(0, 0, 1);
      wb_valid = 0; step(0, 0, 1);

      // x0 is never tracked
      iss(1, 0, 0, 0, 0, 0, 1); step(0, 0, 1);
      iss(1, 0, 1, 0, 1, 0, 0); step(0, 0, 1);

      // Redirect over a RAW hazard, then redirect during flush
      iss(1, 0, 0, 0, 0, 9, 1); step(0, 0, 1);
      iss(1, 9, 1, 0, 0, 9, 1); redirect = 1; step(0, 1, 0);
      chk("flush_cnt_n1", flush_cnt, 32'd1);
      redirect = 0; step(0, 1, 0);
      step(1, 0, 0);
      redirect = 1; step(0, 1, 0); step(0, 1, 0);
      redirect = 0; step(0, 1, 0);
      chk("flush_cnt_re", flush_cnt, 32'd3);
      step(1, 0, 0);
      idle(); wb_valid = 1; wb_addr = 9; step(0, 0, 0);
      wb_valid = 0;

      // Saturation at MAX_INFLIGHT writers
      iss(1, 0, 0, 0, 0, 7, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1); step(1, 0, 0);
      wb_valid = 1; wb_addr = 7; step(0, 0, 1);
      wb_valid = 0; step(1, 0, 0);
      idle(); wb_valid = 1; wb_addr = 7; step(); step(); step();
      wb_valid = 0;
      iss(1, 7, 1, 0, 0, 0, 0); step(0, 0, 1);

      // Reset abandons pending writers and an active flush
      iss(1, 0, 0, 0, 0, 3, 1); step(0, 0, 1); step(0, 0, 1);
      idle(); redirect = 1; step(0, 1, 0);
      redirect = 1; rst = 1; iss(1, 3, 1, 0, 0, 0, 0); step(0, 0, 0);
      rst = 0; redirect = 0;
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);
      step(0, 0, 1);

      // Random traffic over a small register window to provoke hazards
      for (int c = 0; c < 3000; c++) begin
         iss($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) != 0);
         redirect = ($urandom_range(0, 7) == 0);
         rst      = ($urandom_range(0, 199) == 0);
         cand.delete();
         for (int r = 1; r < 8; r++) if (pend_m[r] > 0) cand.push_back(r);
         wb_valid = 0;
         wb_addr  = 0;
         if ($urandom_range(0, 1) != 0) begin
            wb_valid = 1;
            if (cand.size() > 0) wb_addr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
